// File: rtl/ps2_rx_pkg.sv
// Shared types, register map and FIFO entry layout for the multi-channel PS/2 receiver.
package ps2_rx_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } ps2_state_e;

    localparam logic [3:0] ADDR_DATA   = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_CTRL   = 4'h8;

    localparam int unsigned ENTRY_VALID    = 31;
    localparam int unsigned ENTRY_CHAN_LSB = 16;
    localparam int unsigned ENTRY_ERR      = 8;

    localparam int unsigned STATUS_EMPTY      = 0;
    localparam int unsigned STATUS_FULL       = 1;
    localparam int unsigned STATUS_OVF        = 2;
    localparam int unsigned STATUS_COUNT_LSB  = 8;
    localparam int unsigned STATUS_ERRCNT_LSB = 16;

    localparam int unsigned CTRL_IRQ_EN = 31;

    function automatic logic [31:0] make_entry(input logic [7:0] chan, input logic err,
                                               input logic [7:0] data);
        logic [31:0] e;
        e                         = '0;
        e[ENTRY_VALID]            = 1'b1;
        e[ENTRY_CHAN_LSB +: 8]    = chan;
        e[ENTRY_ERR]              = err;
        e[7:0]                    = data;
        return e;
    endfunction

endpackage

// File: rtl/ps2_rx_multi_if.sv
// Wishbone slave bus bundle between the Caravel bus master and the PS/2 receiver.
interface ps2_rx_multi_if;

    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

endinterface

// File: rtl/ps2_rx_chan.sv
// One PS/2 receive channel: synchroniser, falling-edge detect, frame FSM, timeout, holding register.
// PS2_RX_PARITY_DROP_EN: errored frames are reported on err_frame_o instead of being held.
module ps2_rx_chan
    import ps2_rx_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    input  logic       en_i,
    input  logic       grant_i,
    output logic       hold_full_o,
    output logic [7:0] hold_byte_o,
    output logic       hold_err_o,
    output logic       ovf_o,
    output logic       err_frame_o
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    clk_sync_q, clk_sync_d;
    logic [1:0]    data_sync_q, data_sync_d;
    logic          clk_prev_q, clk_prev_d;
    ps2_state_e    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          hold_full_q, hold_full_d;
    logic [7:0]    hold_byte_q, hold_byte_d;
    logic          hold_err_q, hold_err_d;

    logic fall, data_s, timeout, frame_done, frame_err, drop_err;

    assign data_s  = data_sync_q[1];
    assign fall    = clk_prev_q & ~clk_sync_q[1];
    assign timeout = (state_q != StIdle) && !fall && (tmo_q == TimeoutLast);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state_q <= StIdle;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!en_i || timeout) begin
            state_d = StIdle;
        end else if (fall) begin
            unique case (state_q)
                StIdle:   if (!data_s) state_d = StData;
                StData:   if (bit_cnt_q == 3'd7) state_d = StParity;
                StParity: state_d = StStop;
                StStop:   state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        frame_done = en_i && fall && (state_q == StStop);
        // Odd parity over data+parity, and the stop bit must be high.
        frame_err  = ~(^{shift_q, parity_q}) | ~data_s;
    end

    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2_clk_i};
        data_sync_d = {data_sync_q[0], ps2_data_i};
        clk_prev_d  = clk_sync_q[1];
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        parity_d    = parity_q;
        tmo_d       = (state_q == StIdle || fall) ? '0 : tmo_q + 1'b1;
        if (fall && en_i) begin
            case (state_q)
                StIdle:   bit_cnt_d = '0;
                StData: begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
                StParity: parity_d = data_s;
                default:  ;
            endcase
        end

        drop_err = 1'b0;
`ifdef PS2_RX_PARITY_DROP_EN
        drop_err = frame_err;
`endif
        hold_full_d = hold_full_q & ~grant_i;
        hold_byte_d = hold_byte_q;
        hold_err_d  = hold_err_q;
        ovf_o       = 1'b0;
        err_frame_o = frame_done & drop_err;
        if (frame_done && !drop_err) begin
            if (hold_full_q) begin
                ovf_o = 1'b1;
            end else begin
                hold_full_d = 1'b1;
                hold_byte_d = shift_q;
                hold_err_d  = frame_err;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            tmo_q       <= '0;
            hold_full_q <= 1'b0;
            hold_byte_q <= '0;
            hold_err_q  <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            tmo_q       <= tmo_d;
            hold_full_q <= hold_full_d;
            hold_byte_q <= hold_byte_d;
            hold_err_q  <= hold_err_d;
        end
    end

    assign hold_full_o = hold_full_q;
    assign hold_byte_o = hold_byte_q;
    assign hold_err_o  = hold_err_q;

endmodule

// File: rtl/ps2_rx_multi.sv
// Multi-channel PS/2 receiver top: arbiter, shared FIFO, wishbone register file and irq.
// PS2_RX_PARITY_DROP_EN: drop errored frames and count them in STATUS[23:16].
module ps2_rx_multi
    import ps2_rx_pkg::*;
#(
    parameter int unsigned CHANNELS       = 2,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic [CHANNELS-1:0] ps2_clk_i,
    input  logic [CHANNELS-1:0] ps2_data_i,
    ps2_rx_multi_if.slave       wb,
    output logic                irq_o
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [CHANNELS-1:0] hold_full, hold_err, grant, chan_ovf, chan_err_frame;
    logic [7:0]          hold_byte [CHANNELS];
    logic [CHANNELS-1:0] en_q, en_d;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        ps2_rx_chan #(
            .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
        ) u_chan (
            .wb_clk_i   (wb_clk_i),
            .wb_rst_i   (wb_rst_i),
            .ps2_clk_i  (ps2_clk_i[g]),
            .ps2_data_i (ps2_data_i[g]),
            .en_i       (en_q[g]),
            .grant_i    (grant[g]),
            .hold_full_o(hold_full[g]),
            .hold_byte_o(hold_byte[g]),
            .hold_err_o (hold_err[g]),
            .ovf_o      (chan_ovf[g]),
            .err_frame_o(chan_err_frame[g])
        );
    end

    logic [31:0]   fifo_mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d, irq_en_q, irq_en_d, irq_q, irq_d, ack_q, ack_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic [31:0]   dat_q, dat_d, push_entry, rdata;
    logic          push_valid, push_ok, pop, empty, full, access, rd_acc, wr_acc, ovf_clr;
    logic [3:0]    reg_off;

    // Lowest-index full holding register wins; it is released even if the FIFO drops it.
    always_comb begin
        grant      = '0;
        push_valid = 1'b0;
        push_entry = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (hold_full[i] && !push_valid) begin
                grant[i]   = 1'b1;
                push_valid = 1'b1;
                push_entry = make_entry(8'(i), hold_err[i], hold_byte[i]);
            end
        end
    end

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign access  = wb.wbs_stb_i & wb.wbs_cyc_i & ~ack_q;
    assign rd_acc  = access & ~wb.wbs_we_i;
    assign wr_acc  = access & wb.wbs_we_i;
    assign reg_off = {wb.wbs_adr_i[3:2], 2'b00};
    assign pop     = rd_acc && (reg_off == ADDR_DATA) && !empty;
    assign push_ok = push_valid && !full;
    assign ovf_clr = wr_acc && (reg_off == ADDR_STATUS) && wb.wbs_dat_i[STATUS_OVF];

    always_comb begin
        rdata = '0;
        case (reg_off)
            ADDR_DATA:   if (!empty) rdata = fifo_mem_q[rd_ptr_q];
            ADDR_STATUS: begin
                rdata[STATUS_EMPTY]               = empty;
                rdata[STATUS_FULL]                = full;
                rdata[STATUS_OVF]                 = ovf_q;
                rdata[STATUS_COUNT_LSB +: 8]      = 8'(count_q);
                rdata[STATUS_ERRCNT_LSB +: 8]     = err_cnt_q;
            end
            ADDR_CTRL: begin
                rdata[CHANNELS-1:0] = en_q;
                rdata[CTRL_IRQ_EN]  = irq_en_q;
            end
            default: rdata = '0;
        endcase
    end

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop);
        ack_d    = access;
        dat_d    = rd_acc ? rdata : '0;
        irq_d    = irq_en_q & ~empty;

        ovf_d = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if ((|chan_ovf) || (push_valid && full)) ovf_d = 1'b1;

        en_d     = en_q;
        irq_en_d = irq_en_q;
        if (wr_acc && (reg_off == ADDR_CTRL)) begin
            en_d     = wb.wbs_dat_i[CHANNELS-1:0];
            irq_en_d = wb.wbs_dat_i[CTRL_IRQ_EN];
        end

`ifdef PS2_RX_PARITY_DROP_EN
        err_cnt_d = ovf_clr ? 8'h00 : err_cnt_q;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (chan_err_frame[i] && (err_cnt_d != 8'hFF)) err_cnt_d = err_cnt_d + 8'd1;
        end
`else
        err_cnt_d = '0;
`endif
    end

    always_ff @(posedge wb_clk_i) begin
        if (push_ok) fifo_mem_q[wr_ptr_q] <= push_entry;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            err_cnt_q <= '0;
            en_q      <= '1;
            irq_en_q  <= 1'b0;
            irq_q     <= 1'b0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            err_cnt_q <= err_cnt_d;
            en_q      <= en_d;
            irq_en_q  <= irq_en_d;
            irq_q     <= irq_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
        end
    end

    assign wb.wbs_ack_o = ack_q;
    assign wb.wbs_dat_o = dat_q;
    assign irq_o        = irq_q;

    logic unused_bits;
    assign unused_bits = ^{wb.wbs_adr_i, wb.wbs_dat_i, chan_err_frame};

endmodule

// File: tb/tb_ps2_rx_multi.sv
// Directed bench for ps2_rx_multi with a queue-based FIFO/register model checked on every ack.
module tb_ps2_rx_multi;

    localparam int unsigned CH    = 2;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned TMO   = 200;
    localparam int unsigned H     = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] ps2_clk;
    logic [CH-1:0] ps2_dat;
    logic          irq;

    ps2_rx_multi_if wb ();

    ps2_rx_multi #(
        .CHANNELS      (CH),
        .FIFO_DEPTH    (DEPTH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .ps2_clk_i (ps2_clk),
        .ps2_data_i(ps2_dat),
        .wb        (wb),
        .irq_o     (irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0]   model_q [$];
    logic          model_ovf;
    int            model_errcnt;
    logic [CH-1:0] model_en;
    logic          model_irq_en;
    logic [10:0]   frm [CH];

    logic [31:0] req_addr, req_wdata, exp_v;
    logic        req_we, ack_prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic par,
                                             input logic stop);
        return {stop, par, b, 1'b0};
    endfunction

    function automatic logic odd_par(input logic [7:0] b);
        return ~(^b);
    endfunction

    function automatic void model_reset();
        model_q.delete();
        model_ovf    = 1'b0;
        model_errcnt = 0;
        model_en     = '1;
        model_irq_en = 1'b0;
    endfunction

    function automatic void model_frame(input int ch, input logic [7:0] b, input logic par,
                                        input logic stop);
        logic err;
        err = ((^{b, par}) != 1'b1) || (stop != 1'b1);
        if (!model_en[ch]) return;
`ifdef PS2_RX_PARITY_DROP_EN
        if (err) begin
            if (model_errcnt < 255) model_errcnt++;
            return;
        end
`endif
        if (model_q.size() >= DEPTH) model_ovf = 1'b1;
        else model_q.push_back(32'h8000_0000 | (32'(ch) << 16) | (32'(err) << 8) | 32'(b));
    endfunction

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s        = '0;
        s[0]     = (model_q.size() == 0);
        s[1]     = (model_q.size() == DEPTH);
        s[2]     = model_ovf;
        s[15:8]  = 8'(model_q.size());
`ifdef PS2_RX_PARITY_DROP_EN
        s[23:16] = 8'(model_errcnt);
`endif
        return s;
    endfunction

    function automatic logic [31:0] model_ctrl();
        logic [31:0] c;
        c           = '0;
        c[CH-1:0]   = model_en;
        c[31]       = model_irq_en;
        return c;
    endfunction

    // Every acknowledged access is checked against the model; writes update it.
    always @(negedge clk) begin
        if (wb.wbs_ack_o) begin
            check("ack_single", 32'(ack_prev), 32'd0);
            if (!req_we) begin
                case (req_addr[3:0])
                    4'h0: begin
                        exp_v = 32'h0;
                        if (model_q.size() != 0) exp_v = model_q.pop_front();
                        check("model_data", wb.wbs_dat_o, exp_v);
                    end
                    4'h4:    check("model_status", wb.wbs_dat_o, model_status());
                    4'h8:    check("model_ctrl", wb.wbs_dat_o, model_ctrl());
                    default: check("model_rsvd", wb.wbs_dat_o, 32'h0);
                endcase
            end else begin
                if (req_addr[3:0] == 4'h4 && req_wdata[2]) begin
                    model_ovf    = 1'b0;
                    model_errcnt = 0;
                end
                if (req_addr[3:0] == 4'h8) begin
                    model_en     = req_wdata[CH-1:0];
                    model_irq_en = req_wdata[31];
                end
            end
        end
        ack_prev = wb.wbs_ack_o;
    end

    task automatic wb_xfer(input logic [31:0] addr, input logic we, input logic [31:0] wd,
                           output logic [31:0] rd);
        @(negedge clk);
        req_addr      = addr;
        req_we        = we;
        req_wdata     = wd;
        wb.wbs_adr_i  = addr;
        wb.wbs_we_i   = we;
        wb.wbs_dat_i  = wd;
        wb.wbs_stb_i  = 1'b1;
        wb.wbs_cyc_i  = 1'b1;
        @(negedge clk);
        check("ack_latency", 32'(wb.wbs_ack_o), 32'd1);
        for (int i = 0; i < 4 && !wb.wbs_ack_o; i++) @(negedge clk);
        rd           = wb.wbs_dat_o;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        @(negedge clk);
        check("ack_width", 32'(wb.wbs_ack_o), 32'd0);
    endtask

    task automatic wb_read(input logic [31:0] addr, output logic [31:0] rd);
        wb_xfer(addr, 1'b0, 32'h0, rd);
    endtask

    task automatic wb_write(input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] dummy;
        wb_xfer(addr, 1'b1, wd, dummy);
    endtask

    // Clocks out the first nbits of frm[] on every channel in mask, in lockstep.
    task automatic drive_frames(input logic [CH-1:0] mask, input int nbits);
        for (int k = 0; k < nbits; k++) begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) if (mask[c]) ps2_dat[c] = frm[c][k];
            repeat (H) @(negedge clk);
            ps2_clk = ps2_clk & ~mask;
            repeat (H) @(negedge clk);
            ps2_clk = ps2_clk | mask;
        end
        repeat (H) @(negedge clk);
        ps2_dat = ps2_dat | mask;
    endtask

    task automatic send(input int ch, input logic [7:0] b, input logic par, input logic stop);
        frm[ch] = mk_frame(b, par, stop);
        drive_frames(CH'(1) << ch, 11);
        model_frame(ch, b, par, stop);
        repeat (12) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] rd;

    initial begin
        rst          = 1'b1;
        ps2_clk      = '1;
        ps2_dat      = '1;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_adr_i = '0;
        wb.wbs_dat_i = '0;
        req_addr     = '0;
        req_wdata    = '0;
        req_we       = 1'b0;
        ack_prev     = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(wb.wbs_ack_o), 32'd0);
        check("rst_dat", wb.wbs_dat_o, 32'h0);
        check("rst_irq", 32'(irq), 32'd0);
        rst = 1'b0;

        wb_read(32'h4, rd);
        check("rst_status", rd, 32'h0000_0001);
        wb_read(32'h8, rd);
        check("rst_ctrl", rd, 32'h0000_0003);
        wb_read(32'hC, rd);
        check("rsvd_zero", rd, 32'h0);

        // Single byte with irq enabled
        wb_write(32'h8, 32'h8000_0003);
        send(0, 8'h1C, 1'b0, 1'b1);
        check("irq_pending", 32'(irq), 32'd1);
        wb_read(32'h4, rd);
        check("status_cnt1", rd, 32'h0000_0100);
        wb_read(32'h0, rd);
        check("single_byte", rd, 32'h8000_001C);
        check("irq_after_pop", 32'(irq), 32'd0);
        wb_read(32'h4, rd);
        check("status_cnt0", rd, 32'h0000_0001);

        // Parity error on channel 1
        send(1, 8'h1C, 1'b1, 1'b1);
`ifdef PS2_RX_PARITY_DROP_EN
        wb_read(32'h4, rd);
        check("perr_dropped", rd, 32'h0001_0001);
        wb_write(32'h4, 32'h4);
`else
        wb_read(32'h0, rd);
        check("perr_entry", rd, 32'h8001_011C);
`endif

        // Simultaneous completion on both channels
        frm[0] = mk_frame(8'hAA, odd_par(8'hAA), 1'b1);
        frm[1] = mk_frame(8'h55, odd_par(8'h55), 1'b1);
        drive_frames(2'b11, 11);
        model_frame(0, 8'hAA, odd_par(8'hAA), 1'b1);
        model_frame(1, 8'h55, odd_par(8'h55), 1'b1);
        repeat (12) @(negedge clk);
        wb_read(32'h0, rd);
        check("simul_ch0", rd, 32'h8000_00AA);
        wb_read(32'h0, rd);
        check("simul_ch1", rd, 32'h8001_0055);

        // Overflow: nine frames into an eight-deep FIFO
        for (int i = 0; i < 9; i++) send(0, 8'(8'h10 + i), odd_par(8'(8'h10 + i)), 1'b1);
        wb_read(32'h4, rd);
        check("ovf_status", rd, 32'h0000_0806);
        wb_write(32'h4, 32'h4);
        wb_read(32'h4, rd);
        check("ovf_cleared", rd, 32'h0000_0802);
        for (int i = 0; i < 8; i++) begin
            wb_read(32'h0, rd);
            check("ovf_drain", rd, 32'h8000_0010 + 32'(i));
        end
        wb_read(32'h0, rd);
        check("empty_read", rd, 32'h0);

        // Timeout: abandoned partial frame followed by a full one
        frm[0] = mk_frame(8'hFF, 1'b1, 1'b1);
        drive_frames(2'b01, 4);
        repeat (TMO + 20) @(negedge clk);
        send(0, 8'h5A, odd_par(8'h5A), 1'b1);
        wb_read(32'h0, rd);
        check("after_timeout", rd, 32'h8000_005A);
        wb_read(32'h0, rd);
        check("timeout_no_extra", rd, 32'h0);

        // Reset mid-frame and mid-bus-cycle with an entry pending
        send(0, 8'h77, odd_par(8'h77), 1'b1);
        check("irq_before_rst", 32'(irq), 32'd1);
        frm[1] = mk_frame(8'h0F, 1'b1, 1'b1);
        drive_frames(2'b10, 5);
        @(negedge clk);
        rst          = 1'b1;
        req_addr     = 32'h0;
        req_we       = 1'b0;
        wb.wbs_adr_i = 32'h0;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_cyc_i = 1'b1;
        model_reset();
        @(negedge clk);
        check("rst_abort_ack", 32'(wb.wbs_ack_o), 32'd0);
        wb.wbs_stb_i = 1'b0;
        wb.wbs_cyc_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst2_ack", 32'(wb.wbs_ack_o), 32'd0);
        check("rst2_dat", wb.wbs_dat_o, 32'h0);
        check("rst2_irq", 32'(irq), 32'd0);
        wb_read(32'h4, rd);
        check("rst2_status", rd, 32'h0000_0001);
        wb_read(32'h8, rd);
        check("rst2_ctrl", rd, 32'h0000_0003);
        send(1, 8'h3C, odd_par(8'h3C), 1'b1);
        wb_read(32'h0, rd);
        check("post_rst_frame", rd, 32'h8001_003C);

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ps2_rx_multi.md
# ps2_rx_multi

Parametrised multi-channel PS/2 receiver and the successor to the fixed keyboard and mouse inputs in the wiggly_ic user-project designs. It deserialises frames from CHANNELS independent PS/2 clock/data pairs on the io pads. Completed frames go into one shared FIFO, which software reads over the Caravel wishbone slave bus. The block raises an interrupt while data is pending.

## Interface
- CHANNELS, 2: number of PS/2 ports, 1..8.
- FIFO_DEPTH, 8: entries in the shared FIFO; power of two, 2..64.
- TIMEOUT_CYCLES, 20000: idle wb_clk_i cycles that abort a partial frame.

- wb_clk_i  in  1  clock for all logic.
- wb_rst_i  in  1  reset, synchronous, active-high.
- ps2_clk_i  in  CHANNELS  raw PS/2 clock per channel; asynchronous.
- ps2_data_i  in  CHANNELS  raw PS/2 data per channel; asynchronous.
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  wishbone strobe, cycle, write enable.
- wbs_adr_i  in  32  byte address; only bits [3:2] are decoded.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- irq_o  out  1  level interrupt.

## Operation
- Per channel:
  - ps2_clk_i and ps2_data_i each pass through a 2-FF synchroniser.
  - Falling-edge detect on the synchronised clock; data is sampled on that edge.
- Channel FSM:
  - IDLE: on an edge with data=0 (start bit), go to DATA and clear the bit count. Data=1 is ignored.
  - DATA: shift 8 bits LSB-first; after the 8th, go to PARITY.
  - PARITY: capture the bit, go to STOP.
  - STOP: capture the bit and return to IDLE.
  - Frame error (err=1) if parity is not odd over data+parity, or stop≠1.
- Timeout:
  - The per-channel counter resets on every edge and in IDLE.
  - In any state other than IDLE, reaching TIMEOUT_CYCLES forces IDLE. No entry is produced.
- Channel disabled (CTRL bit = 0): the FSM is held in IDLE.
- FIFO entry format: [31]=1 valid, [23:16]=channel index, [8]=err, [7:0]=byte.
- Arbitration:
  - Each channel has a 1-entry holding register.
  - Per cycle, the lowest-index full holding register pushes.
  - A frame that completes while its own holding register is still full is dropped and sets OVF.
- FIFO:
  - A push while count==FIFO_DEPTH is dropped and sets OVF. The full check uses the count before any same-cycle pop.
- Registers:
  - 0x0 DATA (read): returns the head entry and pops it. When the FIFO is empty, returns 0 and does not pop. Writes are ignored.
  - 0x4 STATUS: [0] empty, [1] full, [2] OVF (sticky; write 1 clears), [15:8] count, [23:16] error counter (see Configuration).
  - 0x8 CTRL (R/W): [CHANNELS-1:0] channel enable, [31] irq enable.
  - 0xC: reads 0.
- irq_o is registered: irq_en & ~empty.

## Timing
- Reset values:
  - wbs_ack_o=0, wbs_dat_o=0, irq_o=0.
  - FIFO empty, OVF=0, error counter 0.
  - All FSMs IDLE, all holding registers empty.
  - CTRL enables = all ones, irq_en = 0.
- Reset mid-frame or mid-bus-cycle: the state is discarded at the next edge. No ack is issued for the aborted cycle.
- Input-to-FSM latency: 3 cycles from the raw falling edge (2 sync + 1 edge register).
- Stop-bit edge processed in cycle N: the holding register is full at N+1, and the FIFO push happens at N+1 at the earliest.
- Wishbone:
  - wbs_ack_o rises the cycle after stb&cyc and is held for exactly 1 cycle: ack <= stb & cyc & ~ack.
  - wbs_dat_o is valid with ack.
  - The pop and write side effects occur in the ack cycle.
  - A back-to-back strobe gets its ack 2 cycles apart.
- Push and pop in the same cycle: count is unchanged and both take effect, except when full before the pop (push dropped).
- irq_o follows empty with 1 cycle of latency.

## Configuration
- PS2_RX_PARITY_DROP_EN defined:
  - Frames with err=1 are not pushed.
  - An 8-bit saturating counter (saturates at 255) counts them at STATUS[23:16]; writing 1 to STATUS[2] also clears it.
- PS2_RX_PARITY_DROP_EN undefined:
  - Errored frames are pushed with [8]=1.
  - STATUS[23:16] reads 0.

## Structure
- Package ps2_rx_pkg contains:
  - the FSM state enum (IDLE, DATA, PARITY, STOP);
  - register offsets ADDR_DATA/ADDR_STATUS/ADDR_CTRL;
  - entry bit positions and the STATUS bit indices.
- Sub-module ps2_rx_chan holds one channel's synchroniser, edge detect, FSM, timeout counter and holding register; it is instantiated CHANNELS times.
- The top level contains the arbiter, FIFO, register file and irq logic.

## Test plan
- Single byte: channel 0 sends 0x1C with parity 0 and stop 1; read DATA → 0x8000001C; STATUS count goes 1→0; irq_o=1 (irq_en set) until the pop.
- Parity error: channel 1 sends 0x1C with parity 1. Without the macro, DATA reads 0x8001011C. With the macro, the FIFO stays empty and STATUS[23:16]=1.
- Simultaneous completion: both channels finish 0xAA and 0x55 in the same cycle → reads return 0x800000AA then 0x80010055.
- Overflow: push 9 frames with FIFO_DEPTH=8 and no reads → count=8, OVF=1, first 8 bytes intact. Write 0x4 with 0x4 → OVF=0.
- Timeout: send the start bit plus 3 bits, then hold the clock high for TIMEOUT_CYCLES. Next, send a full frame of 0x5A → only 0x8000005A is read.
- Empty read and reset: reading DATA when empty returns 0 with an ack pulse of exactly 1 cycle. Asserting wb_rst_i mid-frame → all outputs at their reset values, and the next full frame is received correctly.
